// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/D memory-port arbiter.
// Owner encoding and counter width are used by both the RTL and anyone decoding state.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported, variable-latency memory between instruction fetch (IF)
// and data access (D): fixed priority to D, with a starvation counter forcing IF through.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // instruction-fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // data requester
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  // shared memory
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  // pipeline stall
  output logic              stall_o
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]       d_rdata_q, d_rdata_d;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;

  logic starved;
  logic grant_d;
  logic grant_if;

  // D wins unless IF is also waiting and has already lost STARVE_MAX times in a row.
  always_comb begin
    starved  = (starve_q == STARVE_LIM);
    grant_d  = d_req_i & ~(if_req_i & starved);
    grant_if = if_req_i & ~grant_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      starve_q   <= starve_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    starve_d   = starve_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = BUSY;
          owner_d = OWN_D;
          addr_d  = d_addr_i;
          we_d    = d_we_i;
          wdata_d = d_wdata_i;
          if (if_req_i && !starved) begin
            starve_d = starve_q + STARVE_CNT_W'(1);
          end
        end else if (grant_if) begin
          state_d  = BUSY;
          owner_d  = OWN_IF;
          addr_d   = if_addr_i;
          we_d     = 1'b0;
          wdata_d  = '0;
          starve_d = '0;
        end
      end

      BUSY: begin
        if (mem_ready_i) begin
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata_i;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall drops in the ack cycle itself so the pipeline advances with the returned data.
  always_comb begin
    mem_req_o   = (state_q == BUSY);
    mem_we_o    = (state_q == BUSY) & we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    if_ack_o    = (state_q == RESP) & (owner_q == OWN_IF);
    d_ack_o     = (state_q == RESP) & (owner_q == OWN_D);
    if_rdata_o  = if_rdata_q;
    d_rdata_o   = d_rdata_q;
    stall_o     = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-ported memory between the instruction-fetch port (IF) and the data-access port (D, load/store).
- Sits between PC/Instruction_Memory fetch logic, MEM-stage data access and a unified memory that may take several cycles.
- Generates the global pipeline stall while either requester is waiting.
- Fixed priority to D, with an anti-starvation counter that guarantees IF progress.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 4, consecutive D grants made while IF is pending before IF is forced to win (legal range 1..15)

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_i  in  1  reset, synchronous, active-high
if_req_i  in  1  fetch request, level, held until if_ack_o
if_addr_i  in  ADDR_W  fetch address, stable while if_req_i
if_ack_o  out  1  one-cycle completion pulse for fetch
if_rdata_o  out  DATA_W  fetched word, valid when if_ack_o, held afterwards
d_req_i  in  1  data request, level, held until d_ack_o
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_ack_o  out  1  one-cycle completion pulse for data
d_rdata_o  out  DATA_W  load data, valid when d_ack_o, held afterwards
mem_req_o  out  1  request to shared memory
mem_we_o  out  1  write enable to memory
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ready_i
mem_ready_i  in  1  memory completion, sampled only while mem_req_o=1
stall_o  out  1  combinational: (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o)

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; mem_req_o, mem_we_o, if_ack_o and d_ack_o = 0; mem_addr_o, mem_wdata_o, if_rdata_o and d_rdata_o = 0; starve_cnt = 0. Reset overrides everything, including mid-transaction. The aborted requester receives no ack and must re-request.
- FSM states: IDLE, BUSY, RESP. A registered owner bit gives the current grant (D or IF).
- IDLE, per cycle:
  - D only pending: grant D.
  - IF only pending: grant IF.
  - Both pending: grant IF if starve_cnt == STARVE_MAX, else grant D.
  - On any grant: latch owner, address, we and wdata into the mem_* registers (we=0 for IF); go to BUSY.
  - No request: stay in IDLE.
- starve_cnt:
  - +1 when D is granted while if_req_i=1, saturating at STARVE_MAX.
  - Cleared to 0 when IF is granted.
  - Unchanged otherwise.
- BUSY:
  - mem_req_o=1; mem_addr_o, mem_we_o and mem_wdata_o held stable.
  - Stays in BUSY until mem_ready_i=1.
  - On mem_ready_i=1: capture mem_rdata_i into the owner's rdata register (loads and fetches only; stores leave d_rdata_o unchanged), clear mem_req_o, go to RESP.
- RESP: owner's ack = 1 for exactly this cycle; the other ack stays 0; next state IDLE.
- Requesters must drop or replace their request in the cycle after ack. IDLE samples requests fresh, so one request never produces two acks.
- Latency: request seen in IDLE at cycle 0, mem_req_o at cycle 1. With mem_ready_i=1 in cycle 1, ack is in cycle 2. Each extra wait cycle of memory adds one cycle.
- Throughput: at most one transaction per 3 cycles.
- mem_we_o is 0 in every state except BUSY with D owning a store.
- Request inputs that change during BUSY/RESP are ignored. The latched values are used.
- Never more than one outstanding memory transaction.

Decomposition:
- Shared package: state enum {IDLE, BUSY, RESP}; owner constants OWN_IF=0, OWN_D=1; STARVE_CNT_W=4.
- Single module; no sub-module. The starvation counter is small enough to stay inline.

Test Plan:
- Reset, then idle for 5 cycles: all outputs 0, stall_o=0; asserting rst_i mid-BUSY returns to IDLE next edge with mem_req_o=0 and no ack.
- IF read of 0x40, memory ready after 3 wait cycles with data 0x8C220004: mem_req_o high for 4 cycles at addr 0x40 with we=0; if_ack_o pulses once; if_rdata_o=0x8C220004; stall_o high until the ack cycle.
- D store addr 0x100, data 0xDEADBEEF, ready immediately: mem_we_o=1 and mem_wdata_o=0xDEADBEEF during BUSY; d_ack_o 2 cycles after request; d_rdata_o unchanged.
- IF (0x10) and D load (0x200) requested in the same cycle: D served first, d_ack_o, then IF served, if_ack_o; no overlap of mem_req_o.
- STARVE_MAX=2, IF held and D re-requesting after every ack: grant sequence D, D, IF, D, D, IF; starve_cnt returns to 0 after each IF grant.
- Ready held high continuously with back-to-back IF requests: acks at cycles 2, 5, 8; exactly one ack per request.
